// File: rtl/idma_axis_loopback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : idma_axis_loopback_buffer
// Brief    : AXI-Stream FIFO that loops iDMA stream writes back to stream reads,
//            in cut-through or store-and-forward (packet) mode.
// Revision : 1.0 - initial release
// ============================================================================

package idma_axis_loopback_pkg;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [0:0]  user;
  } axis_t_chan_t;

  typedef struct packed {
    axis_t_chan_t t;
    logic         tvalid;
  } axis_req_t;

  typedef struct packed {
    logic tready;
  } axis_rsp_t;
endpackage

module idma_axis_loopback_buffer #(
  parameter int unsigned DataWidth       = 64,
  parameter int unsigned Depth           = 16,
  parameter bit          StoreAndForward = 1'b1,
  parameter type         axis_req_t      = idma_axis_loopback_pkg::axis_req_t,
  parameter type         axis_rsp_t      = idma_axis_loopback_pkg::axis_rsp_t,
  parameter type         axis_t_chan_t   = idma_axis_loopback_pkg::axis_t_chan_t,
  parameter int unsigned StrbWidth       = DataWidth / 8,
  parameter int unsigned CntWidth        = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  axis_req_t           sink_req_i,
  output axis_rsp_t           sink_rsp_o,
  output axis_req_t           src_req_o,
  input  axis_rsp_t           src_rsp_i,
  output logic [CntWidth-1:0] fill_o,
  output logic [CntWidth-1:0] pkt_cnt_o
);

  localparam int unsigned         C_PTR_WIDTH = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] C_DEPTH     = CntWidth'(Depth);
  localparam logic [CntWidth-1:0] C_CNT_ONE   = CntWidth'(1);
  localparam logic [C_PTR_WIDTH-1:0] C_PTR_ONE = C_PTR_WIDTH'(1);

  axis_t_chan_t            r_mem [Depth];
  logic [C_PTR_WIDTH-1:0]  r_wr_ptr;
  logic [C_PTR_WIDTH-1:0]  r_rd_ptr;
  logic [CntWidth-1:0]     r_fill;
  logic [CntWidth-1:0]     r_pkt_cnt;
  axis_t_chan_t            w_head;
  logic                    w_sink_ready;
  logic                    w_release;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_push_last;
  logic                    w_pop_last;

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("idma_axis_loopback_buffer: Depth must be a power of two >= 2");
  end

  if (StrbWidth * 8 != DataWidth) begin : g_bad_strb
    $error("idma_axis_loopback_buffer: StrbWidth must equal DataWidth/8");
  end

  assign w_head       = r_mem[r_rd_ptr];
  // Gated by rst_ni so the DMA sees tready low for the whole reset window.
  assign w_sink_ready = rst_ni && (r_fill < C_DEPTH) && !clear_i;

  if (StoreAndForward) begin : g_saf
    // Full FIFO releases anyway, otherwise a packet longer than Depth deadlocks.
    assign w_release = (r_fill != '0) && ((r_pkt_cnt != '0) || (r_fill == C_DEPTH));
  end else begin : g_ct
    assign w_release = (r_fill != '0);
  end

  assign w_push      = sink_req_i.tvalid && w_sink_ready;
  assign w_pop       = w_release && src_rsp_i.tready;
  assign w_push_last = w_push && sink_req_i.t.last;
  assign w_pop_last  = w_pop && w_head.last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fill    <= '0;
      r_pkt_cnt <= '0;
    end else if (clear_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fill    <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;

      if (w_push && !w_pop)      r_fill <= r_fill + C_CNT_ONE;
      else if (!w_push && w_pop) r_fill <= r_fill - C_CNT_ONE;

      if (w_push_last && !w_pop_last)      r_pkt_cnt <= r_pkt_cnt + C_CNT_ONE;
      else if (!w_push_last && w_pop_last) r_pkt_cnt <= r_pkt_cnt - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= sink_req_i.t;
  end

  // Empty FIFO presents all-zero payload instead of stale storage.
  always_comb begin
    src_req_o        = '0;
    src_req_o.tvalid = w_release;
    if (r_fill != '0) src_req_o.t = w_head;
  end

  always_comb begin
    sink_rsp_o        = '0;
    sink_rsp_o.tready = w_sink_ready;
  end

  assign fill_o    = r_fill;
  assign pkt_cnt_o = r_pkt_cnt;

endmodule

`default_nettype wire

// File: doc/idma_axis_loopback_buffer.md
# idma_axis_loopback_buffer

AXI-Stream endpoint that terminates the iDMA backend's streaming write port and sources its streaming read port. Beats the DMA writes out are buffered in an internal FIFO and returned to the DMA's stream read side, giving memory→stream→memory loopback for bring-up and regression. The block sits beside the descriptor/AXIS-backend DMA top, wired to `streaming_wr_req_o/rsp_i` and `streaming_rd_req_i/rsp_o`. It supports cut-through and store-and-forward (packet) modes.

## Interface
- `DataWidth`, 64: stream `tdata` width in bits; `StrbWidth = DataWidth/8` (derived, do not override).
- `Depth`, 16: FIFO depth in beats; power of two, ≥2.
- `StoreAndForward`, 1'b1: 1 = release beats only once their packet's `tlast` beat is stored.
- `axis_req_t`, `axis_rsp_t`, `axis_t_chan_t`: AXI-Stream types. `req` = {`t` (`data`, `strb`, `keep`, `last`, `id`, `dest`, `user`), `tvalid`}; `rsp` = {`tready`}.
- `CntWidth = $clog2(Depth+1)`: derived, do not override.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clear_i`  in  1  synchronous flush: drop all stored beats and zero the counters.
- `sink_req_i`  in  axis_req_t  stream from the DMA (connects to `streaming_wr_req_o`).
- `sink_rsp_o`  out  axis_rsp_t  `tready` back to the DMA.
- `src_req_o`  out  axis_req_t  stream to the DMA (connects to `streaming_rd_req_i`).
- `src_rsp_i`  in  axis_rsp_t  `tready` from the DMA.
- `fill_o`  out  CntWidth  beats currently stored.
- `pkt_cnt_o`  out  CntWidth  complete packets (stored `tlast` beats) currently held.

## Operation
- FIFO stores the whole `axis_t_chan_t` per beat. Read pointer and write pointer are `$clog2(Depth)` bits and wrap naturally. Fill is tracked by a separate counter.
- Push when `sink_req_i.tvalid && sink_rsp_o.tready`. Pop when `src_req_o.tvalid && src_rsp_i.tready`.
- `sink_rsp_o.tready = (fill < Depth) && !clear_i`. A full FIFO does not accept a beat even when a pop happens in the same cycle (no full-bypass).
- `src_req_o.t` is the FIFO head. `tvalid` is qualified by the `release` condition:
  - Cut-through (`StoreAndForward=0`): release = `fill != 0`.
  - Store-and-forward: release = `fill != 0 && (pkt_cnt != 0 || fill == Depth)`.
  - The `fill == Depth` term is a deadlock escape for packets longer than `Depth`. In that case the beats of the open packet drain cut-through.
- `pkt_cnt`: +1 on a push with `t.last=1`, −1 on a pop with `t.last=1`; unchanged if both happen in the same cycle. `pkt_cnt` never exceeds `fill`.
- `fill`: +1 on push only, −1 on pop only, unchanged on both or neither.
- `clear_i` has priority over push and pop in the same cycle. It zeroes the pointers, `fill` and `pkt_cnt`. Any beat presented that cycle is not accepted, because `tready` is 0.
- Once `tvalid` is asserted on either side, `t` must stay stable until `tready`. The block guarantees this on the source side; head data changes only after a pop.
- No error reporting. `keep`, `strb` and the sideband fields pass through unmodified.

## Timing
- Reset values:
  - `sink_rsp_o.tready` = 0 while `rst_ni` = 0, and 1 in the first cycle after release.
  - `src_req_o.tvalid` = 0; `src_req_o.t` = '0.
  - `fill_o` = 0; `pkt_cnt_o` = 0.
- Latency, push to head valid: 1 cycle. A beat pushed at edge N is visible on `src_req_o` after edge N, i.e. in cycle N+1.
- Store-and-forward: the first beat of a packet becomes valid in the cycle after its `tlast` beat is pushed.
- Throughput: 1 beat/cycle on each side simultaneously while 0 < fill < Depth.
- `fill_o` and `pkt_cnt_o` are registered and update on the edge after the handshake.
- Reset asserted mid-packet: state is lost immediately (asynchronous). No partial packet survives.

## Test plan
- Cut-through, `Depth=16`: push 4 beats `0xA0..0xA3`, `last` on the 4th, with `src tready=1` → each beat appears 1 cycle after its push, in order; final `fill_o=0`, `pkt_cnt_o=0`.
- Store-and-forward: push 3 beats with `src tready=1` and no `last` → `src tvalid` stays 0 and `fill_o=3`. Push a 4th beat with `last=1` → `tvalid` rises the next cycle and 4 beats drain back-to-back with `last` on the 4th.
- Full/backpressure: `src tready=0`, push 16 beats → `sink tready` goes 0 after the 16th and `fill_o=16`. Raise `src tready` for exactly 1 cycle → `sink tready` returns 1 the next cycle.
- Oversize packet, store-and-forward: push 20 beats with `last` only on the 20th while `src tready=1` → flow starts at `fill=16` (escape), all 20 beats are delivered in order, `pkt_cnt_o` ends at 0.
- Simultaneous events: at `fill=5`, `pkt_cnt=1`, push a `last` beat while popping the stored `last` beat → `fill_o=5`, `pkt_cnt_o=1` unchanged. Assert `clear_i` together with a valid push → next cycle `fill_o=0` and the pushed beat is absent from the output.
- Reset mid-operation: deassert `rst_ni` with `fill=7` → `tvalid=0`, `fill_o=0` and `sink tready=0` immediately. After release, `tready=1` and subsequent traffic is correct.
